// File: rtl/coklu_geri_yaz_if.sv
// Producer-side bus into the retire unit: one push request, result payload and
// exception information per channel, plus the per-channel ready returned to producers.
interface coklu_geri_yaz_if #(
    parameter int KANAL_SAYISI = 3,
    parameter int VERI_BIT     = 32
);
    logic [KANAL_SAYISI-1:0]          kanal_gecerli_i;
    logic [KANAL_SAYISI-1:0]          kanal_hazir_o;
    logic [5*KANAL_SAYISI-1:0]        kanal_rd_i;
    logic [VERI_BIT*KANAL_SAYISI-1:0] kanal_sonuc_i;
    logic [KANAL_SAYISI-1:0]          kanal_yaz_i;
    logic [KANAL_SAYISI-1:0]          kanal_fp_i;
    logic [KANAL_SAYISI-1:0]          kanal_exc_i;
    logic [4*KANAL_SAYISI-1:0]        kanal_mcause_i;
    logic [VERI_BIT*KANAL_SAYISI-1:0] kanal_mepc_i;

    modport master (
        output kanal_gecerli_i, kanal_rd_i, kanal_sonuc_i, kanal_yaz_i,
               kanal_fp_i, kanal_exc_i, kanal_mcause_i, kanal_mepc_i,
        input  kanal_hazir_o
    );

    modport slave (
        input  kanal_gecerli_i, kanal_rd_i, kanal_sonuc_i, kanal_yaz_i,
               kanal_fp_i, kanal_exc_i, kanal_mcause_i, kanal_mepc_i,
        output kanal_hazir_o
    );
endinterface

// File: rtl/coklu_geri_yaz.sv
// Multi-channel write-back: per-channel result FIFOs drained one entry per cycle
// by a round-robin arbiter into the register file, exception report and retire counter.
module coklu_geri_yaz #(
    parameter int KANAL_SAYISI  = 3,
    parameter int FIFO_DERINLIK = 2,
    parameter int VERI_BIT      = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    coklu_geri_yaz_if.slave     kanal,
    input  logic                duraklat_i,
    input  logic                bh_bosalt_i,
    output logic [VERI_BIT-1:0] yazmac_yaz_veri_o,
    output logic [4:0]          yazmac_adres_o,
    output logic                yaz_o,
    output logic                os_yaz_o,
    output logic                exc_o,
    output logic [3:0]          mcause_ic_o,
    output logic [VERI_BIT-1:0] mepc_o,
    output logic                instret_o,
    output logic [63:0]         minstret_o
);
    localparam int AW = $clog2(FIFO_DERINLIK);
    localparam int IW = $clog2(KANAL_SAYISI);

    typedef struct packed {
        logic [4:0]          rd;
        logic [VERI_BIT-1:0] sonuc;
        logic                yaz;
        logic                fp;
        logic                exc;
        logic [3:0]          mcause;
        logic [VERI_BIT-1:0] mepc;
    } kayit_t;

    kayit_t                  giris [KANAL_SAYISI];
    kayit_t                  bas   [KANAL_SAYISI];
    logic [KANAL_SAYISI-1:0] dolu;
    logic [KANAL_SAYISI-1:0] bos_degil;
    logic [KANAL_SAYISI-1:0] itme;
    logic [KANAL_SAYISI-1:0] cekme;

    logic [IW-1:0] oncelik_reg, oncelik_next;
    logic [63:0]   minstret_reg;
    logic [IW-1:0] secim_idx;
    logic          secim_var;
    logic          pop;
    kayit_t        secilen;

    assign kanal.kanal_hazir_o = ~dolu;

    genvar gi;
    generate
        for (gi = 0; gi < KANAL_SAYISI; gi++) begin : g_kanal
            logic [AW-1:0] wr_ptr_reg;
            logic [AW-1:0] rd_ptr_reg;
            logic [AW:0]   count_reg;
            kayit_t        mem_reg [FIFO_DERINLIK];

            assign giris[gi] = {
                kanal.kanal_rd_i[5*gi +: 5],
                kanal.kanal_sonuc_i[VERI_BIT*gi +: VERI_BIT],
                kanal.kanal_yaz_i[gi],
                kanal.kanal_fp_i[gi],
                kanal.kanal_exc_i[gi],
                kanal.kanal_mcause_i[4*gi +: 4],
                kanal.kanal_mepc_i[VERI_BIT*gi +: VERI_BIT]
            };

            // Ready comes from registered occupancy only, so a full FIFO stays
            // closed even in a cycle where its head is being retired.
            assign dolu[gi]      = (count_reg == (AW+1)'(FIFO_DERINLIK));
            assign bos_degil[gi] = (count_reg != '0);
            assign itme[gi]      = kanal.kanal_gecerli_i[gi] && !dolu[gi] && !bh_bosalt_i;
            assign cekme[gi]     = pop && (secim_idx == IW'(gi));
            assign bas[gi]       = mem_reg[rd_ptr_reg];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else if (bh_bosalt_i) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (itme[gi])
                        wr_ptr_reg <= wr_ptr_reg + AW'(1);
                    if (cekme[gi])
                        rd_ptr_reg <= rd_ptr_reg + AW'(1);
                    case ({itme[gi], cekme[gi]})
                        2'b10:   count_reg <= count_reg + (AW+1)'(1);
                        2'b01:   count_reg <= count_reg - (AW+1)'(1);
                        default: count_reg <= count_reg;
                    endcase
                end
            end

            // Payload storage needs no reset: occupancy alone decides validity.
            always_ff @(posedge clk_i) begin
                if (itme[gi])
                    mem_reg[wr_ptr_reg] <= giris[gi];
            end
        end
    endgenerate

    // First non-empty channel scanning upward from the priority pointer.
    always_comb begin
        secim_var = 1'b0;
        secim_idx = '0;
        for (int i = 0; i < KANAL_SAYISI; i++) begin
            int j;
            j = (int'(oncelik_reg) + i) % KANAL_SAYISI;
            if (!secim_var && bos_degil[j]) begin
                secim_var = 1'b1;
                secim_idx = IW'(j);
            end
        end
    end

    assign pop = secim_var && !duraklat_i && !bh_bosalt_i;

    always_comb begin
        oncelik_next = oncelik_reg;
        if (pop)
            oncelik_next = (secim_idx == IW'(KANAL_SAYISI-1)) ? '0 : secim_idx + IW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            oncelik_reg  <= '0;
            minstret_reg <= '0;
        end else begin
            oncelik_reg <= oncelik_next;
            if (pop && !secilen.exc)
                minstret_reg <= minstret_reg + 64'd1;
        end
    end

    always_comb begin
        secilen           = bas[secim_idx];
        yazmac_yaz_veri_o = '0;
        yazmac_adres_o    = '0;
        mcause_ic_o       = '0;
        mepc_o            = '0;
        os_yaz_o          = 1'b0;
        yaz_o             = 1'b0;
        exc_o             = 1'b0;
        instret_o         = 1'b0;
        if (pop) begin
            yazmac_yaz_veri_o = secilen.sonuc;
            yazmac_adres_o    = secilen.rd;
            mcause_ic_o       = secilen.mcause;
            mepc_o            = secilen.mepc;
            exc_o             = secilen.exc;
            instret_o         = !secilen.exc;
            // x0 is hardwired for the integer file only; f0 is a real register.
            os_yaz_o          = secilen.yaz && secilen.fp && !secilen.exc;
            yaz_o             = os_yaz_o ||
                                (secilen.yaz && !secilen.fp && !secilen.exc && (secilen.rd != 5'd0));
        end
    end

    assign minstret_o = minstret_reg;
endmodule

// File: tb/tb_coklu_geri_yaz.sv
// Randomized and directed checks of coklu_geri_yaz against a queue-based model
// of the per-channel buffers and the round-robin retire order.
module tb_coklu_geri_yaz;
    localparam int K = 3;
    localparam int D = 2;
    localparam int V = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    coklu_geri_yaz_if #(.KANAL_SAYISI(K), .VERI_BIT(V)) kif ();

    logic          duraklat, bosalt;
    logic [V-1:0]  veri, mepc;
    logic [4:0]    adres;
    logic          yaz, os_yaz, exc, instret;
    logic [3:0]    mcause;
    logic [63:0]   minstret;

    coklu_geri_yaz #(.KANAL_SAYISI(K), .FIFO_DERINLIK(D), .VERI_BIT(V)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .kanal             (kif.slave),
        .duraklat_i        (duraklat),
        .bh_bosalt_i       (bosalt),
        .yazmac_yaz_veri_o (veri),
        .yazmac_adres_o    (adres),
        .yaz_o             (yaz),
        .os_yaz_o          (os_yaz),
        .exc_o             (exc),
        .mcause_ic_o       (mcause),
        .mepc_o            (mepc),
        .instret_o         (instret),
        .minstret_o        (minstret)
    );

    typedef struct {
        logic [4:0]   rd;
        logic [V-1:0] sonuc;
        logic         yaz, fp, exc;
        logic [3:0]   mcause;
        logic [V-1:0] mepc;
    } kayit_t;

    kayit_t      kuyruk [K][$];
    int          m_oncelik;
    logic [63:0] m_minstret;

    kayit_t      st [K];
    logic [K-1:0] st_gec;
    logic        st_dur, st_bos;

    int karsilastirma = 0;
    int uyusmazlik    = 0;

    task automatic kontrol(input string etiket, input logic [63:0] gozlenen, input logic [63:0] beklenen);
        karsilastirma++;
        if (gozlenen !== beklenen) begin
            uyusmazlik++;
            $display("FAIL %s: got %0h expected %0h at %0t", etiket, gozlenen, beklenen, $time);
        end
    endtask

    task automatic bosta();
        st_gec = '0;
        st_dur = 1'b0;
        st_bos = 1'b0;
        for (int k = 0; k < K; k++) st[k] = '{default: 0};
    endtask

    task automatic kanal_ayarla(input int k, input logic [4:0] rd, input logic [V-1:0] s,
                                input logic y, input logic f, input logic x,
                                input logic [3:0] mc, input logic [V-1:0] pc);
        st_gec[k] = 1'b1;
        st[k] = '{rd: rd, sonuc: s, yaz: y, fp: f, exc: x, mcause: mc, mepc: pc};
    endtask

    // One clock: apply stimulus, check outputs mid-cycle, advance the model at the edge.
    task automatic tik();
        int     g;
        kayit_t e;
        logic   b_os, b_int, b_yaz;
        logic [K-1:0] b_hazir;
        for (int k = 0; k < K; k++) begin
            kif.kanal_gecerli_i[k]        = st_gec[k];
            kif.kanal_rd_i[5*k +: 5]      = st[k].rd;
            kif.kanal_sonuc_i[V*k +: V]   = st[k].sonuc;
            kif.kanal_yaz_i[k]            = st[k].yaz;
            kif.kanal_fp_i[k]             = st[k].fp;
            kif.kanal_exc_i[k]            = st[k].exc;
            kif.kanal_mcause_i[4*k +: 4]  = st[k].mcause;
            kif.kanal_mepc_i[V*k +: V]    = st[k].mepc;
        end
        duraklat = st_dur;
        bosalt   = st_bos;
        @(negedge clk);
        g = -1;
        if (!st_dur && !st_bos)
            for (int i = 0; i < K; i++) begin
                int j;
                j = (m_oncelik + i) % K;
                if (g < 0 && kuyruk[j].size() > 0) g = j;
            end
        if (g >= 0) e = kuyruk[g][0];
        else        e = '{default: 0};
        b_os  = (g >= 0) && e.yaz && e.fp && !e.exc;
        b_int = (g >= 0) && e.yaz && !e.fp && !e.exc && (e.rd != 0);
        b_yaz = b_os || b_int;
        for (int k = 0; k < K; k++) b_hazir[k] = (kuyruk[k].size() < D);
        kontrol("hazir",    kif.kanal_hazir_o, b_hazir);
        kontrol("yaz",      yaz,      b_yaz);
        kontrol("os_yaz",   os_yaz,   b_os);
        kontrol("adres",    adres,    e.rd);
        kontrol("veri",     veri,     e.sonuc);
        kontrol("exc",      exc,      (g >= 0) && e.exc);
        kontrol("mcause",   mcause,   e.mcause);
        kontrol("mepc",     mepc,     e.mepc);
        kontrol("instret",  instret,  (g >= 0) && !e.exc);
        kontrol("minstret", minstret, m_minstret);
        if (g >= 0)
            $display("retire ch=%0d rd=%0d veri=%08h yaz=%0b fp=%0b exc=%0b minstret=%0d",
                     g, e.rd, e.sonuc, b_yaz, e.fp, e.exc, m_minstret);
        @(posedge clk);
        if (st_bos) begin
            for (int k = 0; k < K; k++) kuyruk[k].delete();
        end else begin
            for (int k = 0; k < K; k++)
                if (st_gec[k] && kuyruk[k].size() < D) kuyruk[k].push_back(st[k]);
            if (g >= 0) begin
                void'(kuyruk[g].pop_front());
                m_oncelik = (g + 1) % K;
                if (!e.exc) m_minstret = m_minstret + 64'd1;
            end
        end
        #1;
    endtask

    task automatic sifirla();
        #2;
        rst_n = 1'b0;
        #1;
        kontrol("rst_hazir",    kif.kanal_hazir_o, {K{1'b1}});
        kontrol("rst_yaz",      {yaz, os_yaz, exc, instret}, 4'b0);
        kontrol("rst_veri",     veri, 0);
        kontrol("rst_minstret", minstret, 0);
        for (int k = 0; k < K; k++) kuyruk[k].delete();
        m_oncelik  = 0;
        m_minstret = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] m_kayit;
        m_oncelik  = 0;
        m_minstret = '0;
        bosta();
        kif.kanal_gecerli_i = '0;
        duraklat = 1'b0;
        bosalt   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        sifirla();

        // Single push on channel 0, retired the following cycle.
        kanal_ayarla(0, 5'd5, 32'h1234, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        tik();
        bosta();
        tik();
        kontrol("tek_minstret", minstret, 64'd1);
        tik();

        // All three channels at once from priority 0.
        sifirla();
        for (int k = 0; k < K; k++)
            kanal_ayarla(k, 5'(k + 1), 32'(32'hA0 + k), 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        tik();
        bosta();
        repeat (4) tik();

        // Stalled channel 1 fills after two pushes; third is refused.
        bosta();
        st_dur = 1'b1;
        for (int n = 0; n < 3; n++) begin
            kanal_ayarla(1, 5'(10 + n), 32'(32'hB0 + n), 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
            tik();
        end
        kontrol("dolu_hazir1", kif.kanal_hazir_o[1], 1'b0);
        bosta();
        repeat (3) tik();

        // Exception entry on channel 2.
        m_kayit = m_minstret;
        kanal_ayarla(2, 5'd7, 32'hDEAD, 1'b1, 1'b0, 1'b1, 4'd2, 32'h80000100);
        tik();
        bosta();
        tik();
        kontrol("exc_minstret", minstret, m_kayit);

        // Writes to register 0, integer then FP.
        kanal_ayarla(0, 5'd0, 32'h55, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        tik();
        bosta();
        tik();
        kanal_ayarla(1, 5'd0, 32'h66, 1'b1, 1'b1, 1'b0, 4'd0, 32'd0);
        tik();
        bosta();
        tik();

        // Flush with two buffered entries and a simultaneous push.
        m_kayit = m_minstret;
        st_dur = 1'b1;
        kanal_ayarla(0, 5'd3, 32'h77, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        kanal_ayarla(1, 5'd4, 32'h88, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        tik();
        bosta();
        st_bos = 1'b1;
        kanal_ayarla(2, 5'd9, 32'h99, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        tik();
        bosta();
        tik();
        kontrol("bosalt_hazir",    kif.kanal_hazir_o, {K{1'b1}});
        kontrol("bosalt_minstret", minstret, m_kayit);

        // Random traffic with stalls, flushes and one mid-run reset.
        for (int c = 0; c < 600; c++) begin
            bosta();
            for (int k = 0; k < K; k++)
                if ($urandom_range(0, 99) < 45)
                    kanal_ayarla(k, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                                 $urandom, 1'($urandom), 1'($urandom),
                                 ($urandom_range(0, 5) == 0), 4'($urandom), $urandom);
            st_dur = ($urandom_range(0, 4) == 0);
            st_bos = ($urandom_range(0, 24) == 0);
            tik();
            if (c == 300) begin
                bosta();
                tik();
                sifirla();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", karsilastirma, uyusmazlik);
        $finish;
    end
endmodule
